// File: rtl/axi_pkg.sv
// Shared AXI4 definitions for the memory responder slice.
// Response/burst codes, channel FSM states, address range check.
package axi_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  localparam logic [1:0] FIXED = 2'b00;
  localparam logic [1:0] INCR  = 2'b01;
  localparam logic [1:0] WRAP  = 2'b10;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_t;

  // Subtract-then-compare so base+span never overflows.
  function automatic logic in_range(
    input logic [63:0] addr,
    input logic [63:0] base,
    input logic [63:0] span
  );
    return (addr >= base) && ((addr - base) < span);
  endfunction

endpackage

// File: rtl/axi_mem_array.sv
// Word-organised storage for the AXI memory responder.
// Ports: i_clock; comb read i_ridx->o_rdata; write i_we/i_widx/i_wdata/i_wstrb.
module axi_mem_array #(
  parameter int DATA_W    = 64,
  parameter int MEM_WORDS = 4096
) (
  input  logic                         i_clock,
  input  logic [$clog2(MEM_WORDS)-1:0] i_ridx,
  output logic [DATA_W-1:0]            o_rdata,
  input  logic                         i_we,
  input  logic [$clog2(MEM_WORDS)-1:0] i_widx,
  input  logic [DATA_W-1:0]            i_wdata,
  input  logic [DATA_W/8-1:0]          i_wstrb
);

  logic [DATA_W-1:0] r_mem [MEM_WORDS];

  assign o_rdata = r_mem[i_ridx];

  always_ff @(posedge i_clock) begin
    if (i_we) begin
      for (int i = 0; i < DATA_W/8; i++) begin
        if (i_wstrb[i]) begin
          r_mem[i_widx][8*i +: 8] <= i_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 slave backed by a byte-strobed memory; one burst per direction.
// Ports: i_clock/i_reset, AW/W/B write channels, AR/R read channels.
module axi_mem_responder
  import axi_pkg::*;
#(
  parameter int          ADDR_W    = 64,
  parameter int          DATA_W    = 64,
  parameter int          ID_W      = 4,
  parameter int          USER_W    = 1,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
  parameter int          MEM_WORDS = 4096
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_awvalid,
  output logic                o_awready,
  input  logic [ADDR_W-1:0]   i_awaddr,
  input  logic [ID_W-1:0]     i_awid,
  input  logic [7:0]          i_awlen,
  input  logic [2:0]          i_awsize,
  input  logic [1:0]          i_awburst,
  input  logic [2:0]          i_awprot,
  input  logic                i_awlock,
  input  logic [3:0]          i_awcache,
  input  logic [3:0]          i_awqos,
  input  logic [USER_W-1:0]   i_awuser,
  input  logic                i_wvalid,
  output logic                o_wready,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic [DATA_W/8-1:0] i_wstrb,
  input  logic                i_wlast,
  output logic                o_bvalid,
  input  logic                i_bready,
  output logic [1:0]          o_bresp,
  output logic [ID_W-1:0]     o_bid,
  output logic [USER_W-1:0]   o_buser,
  input  logic                i_arvalid,
  output logic                o_arready,
  input  logic [ADDR_W-1:0]   i_araddr,
  input  logic [ID_W-1:0]     i_arid,
  input  logic [7:0]          i_arlen,
  input  logic [2:0]          i_arsize,
  input  logic [1:0]          i_arburst,
  input  logic [2:0]          i_arprot,
  input  logic                i_arlock,
  input  logic [3:0]          i_arcache,
  input  logic [3:0]          i_arqos,
  input  logic [USER_W-1:0]   i_aruser,
  output logic                o_rvalid,
  input  logic                i_rready,
  output logic [DATA_W-1:0]   o_rdata,
  output logic [1:0]          o_rresp,
  output logic                o_rlast,
  output logic [ID_W-1:0]     o_rid,
  output logic [USER_W-1:0]   o_ruser
);

  localparam int          STRB_W = DATA_W / 8;
  localparam int          OFF_W  = $clog2(STRB_W);
  localparam int          IDX_W  = $clog2(MEM_WORDS);
  localparam logic [63:0] SPAN   = 64'(MEM_WORDS) * 64'(STRB_W);

  logic w_unused;
  assign w_unused = ^{i_awprot, i_awlock, i_awcache, i_awqos,
                      i_awuser, i_arprot, i_arlock, i_arcache,
                      i_arqos, i_aruser};

  assign o_buser = '0;
  assign o_ruser = '0;

  // ---------------- read channel ----------------
  rd_state_t         r_rstate, w_rstate_nxt;
  logic [ADDR_W-1:0] r_raddr;
  logic [ID_W-1:0]   r_rid;
  logic [7:0]        r_rlen, r_rbeat;
  logic [2:0]        r_rsize;
  logic [1:0]        r_rburst;
  logic              w_rin, w_rbad, w_ar_hs, w_r_hs;
  logic [IDX_W-1:0]  w_ridx;
  logic [DATA_W-1:0] w_mem_rdata;

  assign w_rin   = in_range(64'(r_raddr), BASE_ADDR, SPAN);
  assign w_rbad  = (r_rburst == WRAP) || (r_rsize > 3'(OFF_W));
  assign w_ridx  = IDX_W'((64'(r_raddr) - BASE_ADDR) >> OFF_W);
  assign w_ar_hs = i_arvalid & o_arready;
  assign w_r_hs  = o_rvalid & i_rready;

  always_ff @(posedge i_clock) begin
    if (i_reset) r_rstate <= R_IDLE;
    else         r_rstate <= w_rstate_nxt;
  end

  always_ff @(posedge i_clock) begin
    if (w_ar_hs) begin
      r_raddr  <= i_araddr;
      r_rid    <= i_arid;
      r_rlen   <= i_arlen;
      r_rsize  <= i_arsize;
      r_rburst <= i_arburst;
      r_rbeat  <= '0;
    end else if (w_r_hs) begin
      r_rbeat <= r_rbeat + 8'd1;
      if (r_rburst != FIXED) begin
        r_raddr <= r_raddr + (ADDR_W'(1) << r_rsize);
      end
    end
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    o_arready    = 1'b0;
    o_rvalid     = 1'b0;
    o_rdata      = '0;
    o_rresp      = OKAY;
    o_rlast      = 1'b0;
    o_rid        = '0;
    unique case (r_rstate)
      R_IDLE: begin
        o_arready = 1'b1;
        if (i_arvalid) w_rstate_nxt = R_DATA;
      end
      R_DATA: begin
        o_rvalid = 1'b1;
        o_rid    = r_rid;
        o_rlast  = (r_rbeat == r_rlen);
        o_rdata  = w_rin ? w_mem_rdata : '0;
        o_rresp  = !w_rin ? DECERR :
                   w_rbad ? SLVERR : OKAY;
        if (i_rready && o_rlast) w_rstate_nxt = R_IDLE;
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // ---------------- write channel ----------------
  wr_state_t         r_wstate, w_wstate_nxt;
  logic [ADDR_W-1:0] r_waddr;
  logic [ID_W-1:0]   r_wid;
  logic [7:0]        r_wlen, r_wbeat;
  logic [2:0]        r_wsize;
  logic [1:0]        r_wburst, r_werr;
  logic [1:0]        w_beat_err, w_err_nxt;
  logic              w_win, w_wbad, w_wproto;
  logic              w_aw_hs, w_w_hs, w_we;
  logic [IDX_W-1:0]  w_widx;

  assign w_win    = in_range(64'(r_waddr), BASE_ADDR, SPAN);
  assign w_wbad   = (r_wburst == WRAP) || (r_wsize > 3'(OFF_W));
  assign w_wproto = i_wlast != (r_wbeat == r_wlen);
  assign w_widx   = IDX_W'((64'(r_waddr) - BASE_ADDR) >> OFF_W);
  assign w_aw_hs  = i_awvalid & o_awready;
  assign w_w_hs   = i_wvalid & o_wready;
  assign w_we     = w_w_hs & w_win & ~w_wbad;

  // Codes order numerically: OKAY < SLVERR < DECERR.
  assign w_beat_err = !w_win               ? DECERR :
                      (w_wbad || w_wproto) ? SLVERR : OKAY;
  assign w_err_nxt  = (w_beat_err > r_werr) ? w_beat_err : r_werr;

  always_ff @(posedge i_clock) begin
    if (i_reset) r_wstate <= W_IDLE;
    else         r_wstate <= w_wstate_nxt;
  end

  always_ff @(posedge i_clock) begin
    if (w_aw_hs) begin
      r_waddr  <= i_awaddr;
      r_wid    <= i_awid;
      r_wlen   <= i_awlen;
      r_wsize  <= i_awsize;
      r_wburst <= i_awburst;
      r_wbeat  <= '0;
      r_werr   <= OKAY;
    end else if (w_w_hs) begin
      r_wbeat <= r_wbeat + 8'd1;
      r_werr  <= w_err_nxt;
      if (r_wburst != FIXED) begin
        r_waddr <= r_waddr + (ADDR_W'(1) << r_wsize);
      end
    end
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    o_awready    = 1'b0;
    o_wready     = 1'b0;
    o_bvalid     = 1'b0;
    o_bresp      = OKAY;
    o_bid        = '0;
    unique case (r_wstate)
      W_IDLE: begin
        o_awready = 1'b1;
        if (i_awvalid) w_wstate_nxt = W_DATA;
      end
      W_DATA: begin
        o_wready = 1'b1;
        if (i_wvalid && i_wlast) w_wstate_nxt = W_RESP;
      end
      W_RESP: begin
        o_bvalid = 1'b1;
        o_bresp  = r_werr;
        o_bid    = r_wid;
        if (i_bready) w_wstate_nxt = W_IDLE;
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  axi_mem_array #(
    .DATA_W    (DATA_W),
    .MEM_WORDS (MEM_WORDS)
  ) u_mem (
    .i_clock (i_clock),
    .i_ridx  (w_ridx),
    .o_rdata (w_mem_rdata),
    .i_we    (w_we),
    .i_widx  (w_widx),
    .i_wdata (i_wdata),
    .i_wstrb (i_wstrb)
  );

endmodule

// File: tb/tb_axi_mem_responder.sv
// Scoreboard bench for axi_mem_responder.
// Directed bursts plus randomized traffic against a word-array model.
module tb_axi_mem_responder;
  import axi_pkg::*;

  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam int          WORDS = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        awvalid, awready;
  logic [63:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        wvalid, wready, wlast;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic [3:0]  bid;
  logic [0:0]  buser;
  logic        arvalid, arready;
  logic [63:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid, rready, rlast;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic [3:0]  rid;
  logic [0:0]  ruser;

  axi_mem_responder dut (
    .i_clock(clk), .i_reset(rst),
    .i_awvalid(awvalid), .o_awready(awready),
    .i_awaddr(awaddr), .i_awid(awid), .i_awlen(awlen),
    .i_awsize(awsize), .i_awburst(awburst),
    .i_awprot(3'd0), .i_awlock(1'b0), .i_awcache(4'd0),
    .i_awqos(4'd0), .i_awuser(1'b0),
    .i_wvalid(wvalid), .o_wready(wready), .i_wdata(wdata),
    .i_wstrb(wstrb), .i_wlast(wlast),
    .o_bvalid(bvalid), .i_bready(bready), .o_bresp(bresp),
    .o_bid(bid), .o_buser(buser),
    .i_arvalid(arvalid), .o_arready(arready),
    .i_araddr(araddr), .i_arid(arid), .i_arlen(arlen),
    .i_arsize(arsize), .i_arburst(arburst),
    .i_arprot(3'd0), .i_arlock(1'b0), .i_arcache(4'd0),
    .i_arqos(4'd0), .i_aruser(1'b0),
    .o_rvalid(rvalid), .i_rready(rready), .o_rdata(rdata),
    .o_rresp(rresp), .o_rlast(rlast), .o_rid(rid),
    .o_ruser(ruser)
  );

  typedef struct {
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
    bit          chk_data;
  } rbeat_t;

  typedef struct {
    logic [1:0] resp;
    logic [3:0] id;
  } bexp_t;

  rbeat_t      rq[$];
  bexp_t       bq[$];
  logic [63:0] wq_data[$];
  logic [7:0]  wq_strb[$];
  logic [63:0] mem [WORDS];
  bit          known [WORDS];
  int          n_pass = 0;
  int          n_tot  = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic fail(input string nm);
    n_tot++;
    $display("FAIL %s: timed out, got nothing expected handshake", nm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_in(input logic [63:0] a);
    return (a >= BASE) && ((a - BASE) < 64'(WORDS * 8));
  endfunction

  function automatic int m_idx(input logic [63:0] a);
    return int'((a - BASE) >> 3);
  endfunction

  function automatic logic [63:0] m_addr(input logic [63:0] a,
      input int b, input logic [2:0] sz, input logic [1:0] bu);
    return (bu == FIXED) ? a : a + (64'(b) << sz);
  endfunction

  task automatic exp_read(input logic [63:0] a0, input int len,
      input logic [2:0] sz, input logic [1:0] bu, input logic [3:0] id);
    for (int b = 0; b <= len; b++) begin
      rbeat_t      e;
      logic [63:0] a;
      a = m_addr(a0, b, sz, bu);
      e.id = id;
      e.last = (b == len);
      if (!m_in(a)) begin
        e.resp = DECERR;
        e.data = 64'd0;
        e.chk_data = 1'b1;
      end else begin
        e.resp = (bu == WRAP || sz > 3'd3) ? SLVERR : OKAY;
        e.data = mem[m_idx(a)];
        e.chk_data = known[m_idx(a)];
      end
      rq.push_back(e);
    end
  endtask

  task automatic exp_write(input logic [63:0] a0, input int len,
      input logic [2:0] sz, input logic [1:0] bu, input logic [3:0] id,
      input int wl);
    logic [1:0] worst;
    bexp_t      e;
    worst = OKAY;
    for (int b = 0; b <= wl; b++) begin
      logic [63:0] a;
      logic [1:0]  be;
      a = m_addr(a0, b, sz, bu);
      be = OKAY;
      if (!m_in(a)) be = DECERR;
      else if (bu == WRAP || sz > 3'd3) be = SLVERR;
      else begin
        for (int k = 0; k < 8; k++)
          if (wq_strb[b][k]) mem[m_idx(a)][8*k +: 8] = wq_data[b][8*k +: 8];
        if (wq_strb[b] == 8'hFF) known[m_idx(a)] = 1'b1;
      end
      if (((b == wl) != (b == len)) && be == OKAY) be = SLVERR;
      if (be > worst) worst = be;
    end
    e.resp = worst;
    e.id = id;
    bq.push_back(e);
  endtask

  task automatic fill_w(input int n, input bit rnd_strb);
    wq_data.delete();
    wq_strb.delete();
    for (int i = 0; i < n; i++) begin
      wq_data.push_back({$urandom, $urandom});
      wq_strb.push_back(rnd_strb ? 8'($urandom) : 8'hFF);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    rbeat_t re;
    bexp_t  be;
    if (!rst && rvalid && rready) begin
      if (rq.size() == 0) begin
        n_tot++;
        $display("FAIL r_unexpected: got beat expected none");
      end else begin
        re = rq.pop_front();
        chk("rresp", 64'(rresp), 64'(re.resp));
        chk("rlast", 64'(rlast), 64'(re.last));
        chk("rid", 64'(rid), 64'(re.id));
        if (re.chk_data) chk("rdata", rdata, re.data);
      end
    end
    if (!rst && bvalid && bready) begin
      if (bq.size() == 0) begin
        n_tot++;
        $display("FAIL b_unexpected: got response expected none");
      end else begin
        be = bq.pop_front();
        chk("bresp", 64'(bresp), 64'(be.resp));
        chk("bid", 64'(bid), 64'(be.id));
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic drive_read(input logic [63:0] a, input int len,
      input logic [2:0] sz, input logic [1:0] bu, input logic [3:0] id,
      input int rmode);
    bit hs, done;
    int t;
    araddr = a; arlen = 8'(len); arsize = sz;
    arburst = bu; arid = id; arvalid = 1'b1;
    rready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    hs = 1'b0; t = 0;
    while (!hs && t < 100) begin
      @(negedge clk);
      hs = arvalid && arready;
      tick();
      t++;
    end
    arvalid = 1'b0;
    if (!hs) fail("ar_handshake");
    done = 1'b0; t = 0;
    while (hs && !done && t < 2000) begin
      @(negedge clk);
      if (rmode == 0) chk("r_beat_timing", 64'(rvalid), 64'd1);
      done = rvalid && rready && rlast;
      tick();
      if (rmode != 0) rready = 1'($urandom_range(0, 1));
      t++;
    end
    if (hs && !done) fail("r_last");
    rready = 1'b0;
  endtask

  task automatic drive_write(input logic [63:0] a, input int len,
      input logic [2:0] sz, input logic [1:0] bu, input logic [3:0] id,
      input int wl, input int wmode, input int bmode);
    bit done;
    int t;
    awaddr = a; awlen = 8'(len); awsize = sz;
    awburst = bu; awid = id; awvalid = 1'b1;
    fork
      begin
        bit hs;
        int ta;
        hs = 1'b0; ta = 0;
        while (!hs && ta < 100) begin
          @(negedge clk);
          hs = awvalid && awready;
          tick();
          ta++;
        end
        awvalid = 1'b0;
        if (!hs) fail("aw_handshake");
      end
      begin
        for (int b = 0; b <= wl; b++) begin
          bit hs;
          int tw;
          wdata = wq_data[b]; wstrb = wq_strb[b];
          wlast = (b == wl);
          wvalid = (wmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
          hs = 1'b0; tw = 0;
          while (!hs && tw < 200) begin
            @(negedge clk);
            hs = wvalid && wready;
            tick();
            if (!hs && wmode != 0) wvalid = 1'($urandom_range(0, 1));
            tw++;
          end
          if (!hs) begin
            fail("w_handshake");
            break;
          end
        end
        wvalid = 1'b0;
        wlast = 1'b0;
      end
    join
    t = 0;
    if (bmode == 2) begin
      bready = 1'b0;
      @(negedge clk);
      while (!bvalid && t < 200) begin
        @(negedge clk);
        t++;
      end
      for (int i = 0; i < 5; i++) begin
        chk("b_hold_valid", 64'(bvalid), 64'd1);
        if (bq.size() != 0)
          chk("b_hold_resp", 64'(bresp), 64'(bq[0].resp));
        if (i < 4) begin
          tick();
          @(negedge clk);
        end
      end
      tick();
    end
    bready = (bmode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    done = 1'b0; t = 0;
    while (!done && t < 500) begin
      @(negedge clk);
      done = bvalid && bready;
      tick();
      if (bmode == 1) bready = 1'($urandom_range(0, 1));
      t++;
    end
    if (!done) fail("b_handshake");
    bready = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, t;
    for (int i = 0; i < WORDS; i++) begin
      mem[i] = '0;
      known[i] = 1'b0;
    end
    awvalid = 0; awaddr = 0; awid = 0; awlen = 0; awsize = 0;
    awburst = 0; wvalid = 0; wdata = 0; wstrb = 0; wlast = 0;
    bready = 0; arvalid = 0; araddr = 0; arid = 0; arlen = 0;
    arsize = 0; arburst = 0; rready = 0;

    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_awready", 64'(awready), 64'd1);
    chk("rst_arready", 64'(arready), 64'd1);
    chk("rst_wready", 64'(wready), 64'd0);
    chk("rst_bvalid", 64'(bvalid), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_rlast", 64'(rlast), 64'd0);
    chk("rst_bresp", 64'(bresp), 64'd0);
    chk("rst_rresp", 64'(rresp), 64'd0);
    chk("rst_bid", 64'(bid), 64'd0);
    chk("rst_rid", 64'(rid), 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_users", 64'({buser, ruser}), 64'd0);
    tick();

    // Preload words 0..63 (0..3 hold 0..3) and the last 8 words.
    fill_w(64, 1'b0);
    for (int i = 0; i < 4; i++) wq_data[i] = 64'(i);
    exp_write(BASE, 63, 3'd3, INCR, 4'd1, 63);
    drive_write(BASE, 63, 3'd3, INCR, 4'd1, 63, 0, 0);
    fill_w(8, 1'b0);
    exp_write(BASE + 64'(4088 * 8), 7, 3'd3, INCR, 4'd2, 7);
    drive_write(BASE + 64'(4088 * 8), 7, 3'd3, INCR, 4'd2, 7, 1, 1);

    // 4-beat INCR read, rready held high.
    exp_read(BASE, 3, 3'd3, INCR, 4'd5);
    drive_read(BASE, 3, 3'd3, INCR, 4'd5, 0);

    // Clear word 2, then partial-strobe write and read back.
    fill_w(1, 1'b0);
    wq_data[0] = 64'd0;
    exp_write(BASE + 64'h10, 0, 3'd3, INCR, 4'd3, 0);
    drive_write(BASE + 64'h10, 0, 3'd3, INCR, 4'd3, 0, 0, 0);
    fill_w(1, 1'b0);
    wq_data[0] = 64'h1122334455667788;
    wq_strb[0] = 8'h0F;
    exp_write(BASE + 64'h10, 0, 3'd3, INCR, 4'd4, 0);
    drive_write(BASE + 64'h10, 0, 3'd3, INCR, 4'd4, 0, 0, 0);
    exp_read(BASE + 64'h10, 0, 3'd3, INCR, 4'd6);
    drive_read(BASE + 64'h10, 0, 3'd3, INCR, 4'd6, 0);

    // Read straddling the bottom of the window.
    exp_read(64'h7FFF_FFF8, 1, 3'd3, INCR, 4'd7);
    drive_read(64'h7FFF_FFF8, 1, 3'd3, INCR, 4'd7, 0);

    // Early wlast, B held with bready low.
    fill_w(2, 1'b0);
    exp_write(BASE + 64'h40, 3, 3'd3, INCR, 4'd8, 1);
    drive_write(BASE + 64'h40, 3, 3'd3, INCR, 4'd8, 1, 0, 2);

    // Concurrent read and write of the same word.
    fill_w(1, 1'b0);
    wq_data[0] = 64'hAB;
    exp_read(BASE + 64'h20, 0, 3'd3, INCR, 4'd9);
    exp_write(BASE + 64'h20, 0, 3'd3, INCR, 4'd10, 0);
    fork
      drive_read(BASE + 64'h20, 0, 3'd3, INCR, 4'd9, 0);
      drive_write(BASE + 64'h20, 0, 3'd3, INCR, 4'd10, 0, 0, 0);
    join
    exp_read(BASE + 64'h20, 0, 3'd3, INCR, 4'd11);
    drive_read(BASE + 64'h20, 0, 3'd3, INCR, 4'd11, 0);

    // Reset while beat 2 of an 8-beat read is on the bus.
    exp_read(BASE, 7, 3'd3, INCR, 4'd12);
    araddr = BASE; arlen = 8'd7; arsize = 3'd3;
    arburst = INCR; arid = 4'd12; arvalid = 1'b1; rready = 1'b1;
    tick();
    arvalid = 1'b0;
    cnt = 0; t = 0;
    while (cnt < 2 && t < 50) begin
      @(negedge clk);
      if (rvalid && rready) cnt++;
      tick();
      t++;
    end
    if (cnt < 2) fail("r_before_reset");
    rst = 1'b1;
    rready = 1'b0;
    tick();
    rq.delete();
    @(negedge clk);
    chk("rst_mid_rvalid", 64'(rvalid), 64'd0);
    chk("rst_mid_arready", 64'(arready), 64'd1);
    chk("rst_mid_rlast", 64'(rlast), 64'd0);
    tick();
    rst = 1'b0;
    exp_read(BASE + 64'h8, 2, 3'd3, INCR, 4'd13);
    drive_read(BASE + 64'h8, 2, 3'd3, INCR, 4'd13, 0);

    // Top of memory, WRAP, illegal size, 256-beat bursts.
    exp_read(BASE + 64'(4095 * 8), 1, 3'd3, INCR, 4'd14);
    drive_read(BASE + 64'(4095 * 8), 1, 3'd3, INCR, 4'd14, 1);
    exp_read(BASE + 64'h18, 1, 3'd3, WRAP, 4'd15);
    drive_read(BASE + 64'h18, 1, 3'd3, WRAP, 4'd15, 1);
    exp_read(BASE, 0, 3'd4, INCR, 4'd1);
    drive_read(BASE, 0, 3'd4, INCR, 4'd1, 1);
    fill_w(256, 1'b0);
    exp_write(BASE + 64'h50, 255, 3'd3, FIXED, 4'd2, 255);
    drive_write(BASE + 64'h50, 255, 3'd3, FIXED, 4'd2, 255, 0, 0);
    exp_read(BASE + 64'h50, 0, 3'd3, INCR, 4'd3);
    drive_read(BASE + 64'h50, 0, 3'd3, INCR, 4'd3, 0);
    exp_read(BASE + 64'(3968 * 8), 255, 3'd3, INCR, 4'd4);
    drive_read(BASE + 64'(3968 * 8), 255, 3'd3, INCR, 4'd4, 1);

    // Randomized traffic.
    for (int k = 0; k < 40; k++) begin
      logic [63:0] a;
      logic [2:0]  sz;
      logic [1:0]  bu;
      logic [3:0]  id;
      int          len, wl;
      a = BASE - 64'd64 + 64'($urandom_range(0, 639));
      if ($urandom_range(0, 1) == 1) a[2:0] = 3'd0;
      len = $urandom_range(0, 7);
      sz = ($urandom_range(0, 9) == 0) ? 3'd4 : 3'($urandom_range(0, 3));
      bu = ($urandom_range(0, 5) == 0) ? WRAP : 2'($urandom_range(0, 1));
      id = 4'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        exp_read(a, len, sz, bu, id);
        drive_read(a, len, sz, bu, id, int'($urandom_range(0, 1)));
      end else begin
        wl = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, len + 1)) : len;
        fill_w(wl + 1, 1'($urandom_range(0, 1)));
        exp_write(a, len, sz, bu, id, wl);
        drive_write(a, len, sz, bu, id, wl, 1, 1);
      end
    end

    repeat (3) tick();
    chk("rq_drained", 64'(rq.size()), 64'd0);
    chk("bq_drained", 64'(bq.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/axi_mem_responder.md
Name: axi_mem_responder

Overview:
- AXI4 slave (responder) that terminates the CPU-side master port in simulation and standalone tests.
- Backed by a byte-strobed register-array memory.
- Independent read and write channel FSMs, one outstanding transaction per direction.
- Supports FIXED and INCR bursts up to 256 beats; reports SLVERR and DECERR per beat or per burst.

Parameters:
- ADDR_W, 64, address width (matches AXI_ADDR_WIDTH).
- DATA_W, 64, data width (matches AXI_DATA_WIDTH); power of two, >= 32.
- ID_W, 4, ID width (matches AXI_ID_WIDTH).
- USER_W, 1, user width (matches AXI_USER_WIDTH).
- BASE_ADDR, 64'h8000_0000, first byte address served.
- MEM_WORDS, 4096, depth in DATA_W words; power of two.

Ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- awvalid/awready  in/out  1  write address handshake.
- awaddr  in  ADDR_W; awid  in  ID_W; awlen  in  8; awsize  in  3; awburst  in  2; awprot/awlock/awcache/awqos/awuser  in  misc  accepted and ignored.
- wvalid/wready  in/out  1; wdata  in  DATA_W; wstrb  in  DATA_W/8; wlast  in  1.
- bvalid/bready  out/in  1; bresp  out  2; bid  out  ID_W; buser  out  USER_W (driven 0).
- arvalid/arready  in/out  1; araddr  in  ADDR_W; arid  in  ID_W; arlen  in  8; arsize  in  3; arburst  in  2; arprot/arlock/arcache/arqos/aruser  in  misc  ignored.
- rvalid/rready  out/in  1; rdata  out  DATA_W; rresp  out  2; rlast  out  1; rid  out  ID_W; ruser  out  USER_W (driven 0).

Behaviour:
- Reset (synchronous, active-high, takes effect at clock edge):
  - Both FSMs return to idle.
  - awready=arready=1, wready=bvalid=rvalid=rlast=0, bresp=rresp=0, bid=rid=0, rdata=0.
  - Memory contents are not cleared.
  - Reset mid-burst abandons the burst; no partial B or R beat is issued afterwards.
- Address mapping:
  - A beat is in range iff BASE_ADDR <= addr < BASE_ADDR + MEM_WORDS*DATA_W/8.
  - Word index = (addr - BASE_ADDR) >> log2(DATA_W/8).
- Read FSM, R_IDLE -> R_DATA:
  - R_IDLE: arready=1. On arvalid&arready, latch araddr/arid/arlen/arsize/arburst, clear beat counter, go R_DATA.
  - R_DATA: arready=0, rvalid=1. rdata=mem[idx(cur_addr)], or 0 if out of range.
  - rresp: DECERR 2'b11 if out of range; SLVERR 2'b10 if burst==WRAP(2'b10) or size > log2(DATA_W/8); otherwise OKAY.
  - rlast = (beat == len). rid = latched id.
  - On rvalid&rready: beat+1. INCR: cur_addr += 1<<size. FIXED: address unchanged.
  - On the beat where rlast is set, return to R_IDLE.
  - First R beat appears 1 cycle after the AR handshake. Each later beat needs 1 cycle when rready is held high.
  - rvalid is held, with rdata/rresp stable, while rready=0.
- Write FSM, W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: awready=1. On handshake, latch fields, clear beat counter and error flag, go W_DATA.
  - W_DATA: wready=1. On wvalid&wready, write bytes with wstrb[i]=1 into mem[idx] if in range; otherwise drop the write and set error=DECERR.
  - The error flag also becomes SLVERR if burst==WRAP or size is illegal, and then no bytes are written.
  - wlast before beat==len, or beat==len without wlast: flag SLVERR. The burst ends only on wlast.
  - On wlast go W_RESP.
  - W_RESP: bvalid=1, bid=latched id, bresp=worst error (DECERR > SLVERR > OKAY). On bready go W_IDLE.
  - AW is not accepted while in W_DATA or W_RESP. W beats arriving in W_IDLE are stalled (wready=0).
- Unaligned INCR start addresses: the address advances from the unaligned start; the word index truncates the low bits.
- Simultaneous read and write to the same word in the same cycle: R returns the old data. The write is visible from the next cycle.
- The beat counter is 8 bits. awlen=255 gives 256 beats with no wrap error. The address may run past the top of memory, which gives DECERR per beat.

Decomposition:
- Shared package axi_pkg, placed alongside the defines header:
  - resp codes: OKAY, EXOKAY, SLVERR, DECERR.
  - burst codes: FIXED, INCR, WRAP.
  - rd_state_t {R_IDLE, R_DATA} and wr_state_t {W_IDLE, W_DATA, W_RESP}.
  - function in_range(addr).
- One sub-module, axi_mem_array:
  - MEM_WORDS x DATA_W storage.
  - Combinational read port.
  - Synchronous byte-enable write port.

Test Plan:
1. AR addr=0x8000_0000 len=3 size=3 INCR, rready=1, memory preloaded 0..3 -> rdata 0,1,2,3 on consecutive cycles starting 1 cycle after AR; rlast only on beat 3; rresp=OKAY; rid echoes arid.
2. AW addr=0x8000_0010 len=0, W data=64'h1122334455667788 strb=8'h0F wlast=1 over old 0 -> bresp=OKAY; a following read returns 64'h0000000055667788.
3. AR addr=0x7FFF_FFF8 len=1 INCR -> beat 0 rresp=DECERR rdata=0; beat 1 (0x8000_0000) rresp=OKAY with valid data.
4. AW len=3 with wlast on beat 1 -> burst ends after 2 beats; bresp=SLVERR; bvalid is held with bready=0 for 5 cycles and stays stable.
5. Simultaneous AR and AW to 0x8000_0020, len=0, write 0xAB, rready=1 -> read returns the prior value; a later read returns 0xAB.
6. Reset asserted during beat 2 of an 8-beat read -> next cycle rvalid=0, arready=1; a new AR is serviced normally.
